// File: rtl/dmi_arbiter.sv
// Two-master round-robin arbiter in front of a single DMI port; one transaction in flight.
// Grant in IDLE, one-cycle ISSUE strobe, RDATA_LAT-cycle wait, one-cycle response pulse.
module dmi_arbiter #(
  parameter int RDATA_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_wr,
  input  logic [6:0]  m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_resp_valid,
  output logic [31:0] m0_resp_rdata,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_wr,
  input  logic [6:0]  m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_resp_valid,
  output logic [31:0] m1_resp_rdata,
  output logic        dmi_en,
  output logic        dmi_wr_en,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(RDATA_LAT);

  state_t      state, state_nxt;
  logic        rr;
  logic [2:0]  cnt;
  logic        cap_id;
  logic        cap_wr;
  logic [6:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] resp_dat;
  logic        win;
  logic        hs;

  // Contended requests go to rr; a lone requester always wins.
  always_comb begin
    win = m1_req_valid;
    if (m0_req_valid && m1_req_valid) win = rr;
    hs = (state == IDLE) && (m0_req_valid || m1_req_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt <= 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      cnt       <= 3'd0;
      cap_id    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_addr  <= 7'd0;
      cap_wdata <= 32'd0;
      resp_dat  <= 32'd0;
    end else begin
      if (hs) begin
        cap_id    <= win;
        cap_wr    <= win ? m1_req_wr    : m0_req_wr;
        cap_addr  <= win ? m1_req_addr  : m0_req_addr;
        cap_wdata <= win ? m1_req_wdata : m0_req_wdata;
        rr        <= ~win;
      end
      if (state == ISSUE) cnt <= LAT;
      if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        // Last wait cycle: dmi_rdata is valid now, writes return zero.
        if (cnt <= 3'd1) resp_dat <= cap_wr ? 32'd0 : dmi_rdata;
      end
    end
  end

  always_comb begin
    m0_req_ready  = (state == IDLE) && m0_req_valid && !win;
    m1_req_ready  = (state == IDLE) && m1_req_valid && win;
    dmi_en        = (state == ISSUE);
    dmi_wr_en     = (state == ISSUE) && cap_wr;
    dmi_addr      = cap_addr;
    dmi_wdata     = cap_wdata;
    busy          = (state != IDLE);
    m0_resp_valid = (state == RESP) && !cap_id;
    m1_resp_valid = (state == RESP) && cap_id;
    m0_resp_rdata = m0_resp_valid ? resp_dat : 32'd0;
    m1_resp_rdata = m1_resp_valid ? resp_dat : 32'd0;
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench: instance a uses RDATA_LAT=1, instance b uses RDATA_LAT=4; both share stimulus.
module tb_dmi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_wr, m1_req_valid, m1_req_wr;
  logic [6:0]  m0_req_addr, m1_req_addr;
  logic [31:0] m0_req_wdata, m1_req_wdata, dmi_rdata;

  logic        a_m0_ready, a_m1_ready, a_m0_rv, a_m1_rv, a_en, a_wr_en, a_busy;
  logic [31:0] a_m0_rd, a_m1_rd, a_wdata;
  logic [6:0]  a_addr;
  logic        b_m0_ready, b_m1_ready, b_m0_rv, b_m1_rv, b_en, b_wr_en, b_busy;
  logic [31:0] b_m0_rd, b_m1_rd, b_wdata;
  logic [6:0]  b_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmi_arbiter #(.RDATA_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(a_m0_ready), .m0_req_wr(m0_req_wr),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_resp_valid(a_m0_rv), .m0_resp_rdata(a_m0_rd),
    .m1_req_valid(m1_req_valid), .m1_req_ready(a_m1_ready), .m1_req_wr(m1_req_wr),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_resp_valid(a_m1_rv), .m1_resp_rdata(a_m1_rd),
    .dmi_en(a_en), .dmi_wr_en(a_wr_en), .dmi_addr(a_addr), .dmi_wdata(a_wdata),
    .dmi_rdata(dmi_rdata), .busy(a_busy)
  );

  dmi_arbiter #(.RDATA_LAT(4)) u_b (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(b_m0_ready), .m0_req_wr(m0_req_wr),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_resp_valid(b_m0_rv), .m0_resp_rdata(b_m0_rd),
    .m1_req_valid(m1_req_valid), .m1_req_ready(b_m1_ready), .m1_req_wr(m1_req_wr),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_resp_valid(b_m1_rv), .m1_resp_rdata(b_m1_rd),
    .dmi_en(b_en), .dmi_wr_en(b_wr_en), .dmi_addr(b_addr), .dmi_wdata(b_wdata),
    .dmi_rdata(dmi_rdata), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven and outputs checked there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req_valid = 0; m0_req_wr = 0; m0_req_addr = '0; m0_req_wdata = '0;
    m1_req_valid = 0; m1_req_wr = 0; m1_req_addr = '0; m1_req_wdata = '0;
    dmi_rdata = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_en", {31'd0, a_en}, 32'd0);
    chk("rst_wr_en", {31'd0, a_wr_en}, 32'd0);
    chk("rst_addr", {25'd0, a_addr}, 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_rv", {30'd0, a_m1_rv, a_m0_rv}, 32'd0);
    chk("rst_rdata", a_m0_rd | a_m1_rd, 32'd0);

    // Single read, LAT=1; cycle 0 is the first cycle with rst low.
    rst = 0; m0_req_valid = 1; m0_req_wr = 0; m0_req_addr = 7'h04;
    settle();
    chk("rd_ready", {30'd0, a_m1_ready, a_m0_ready}, 32'd1);
    chk("rd_busy0", {31'd0, a_busy}, 32'd0);
    tick(); m0_req_valid = 0;
    chk("rd_en", {30'd0, a_en, a_wr_en}, 32'd2);
    chk("rd_addr", {25'd0, a_addr}, 32'h04);
    chk("rd_busy1", {31'd0, a_busy}, 32'd1);
    tick(); dmi_rdata = 32'hDEADBEEF;
    chk("rd_en_off", {31'd0, a_en}, 32'd0);
    chk("rd_rv_early", {30'd0, a_m1_rv, a_m0_rv}, 32'd0);
    tick();
    chk("rd_rv", {30'd0, a_m1_rv, a_m0_rv}, 32'd1);
    chk("rd_rdata", a_m0_rd, 32'hDEADBEEF);
    chk("rd_busy3", {31'd0, a_busy}, 32'd1);
    tick();
    chk("rd_idle", {31'd0, a_busy}, 32'd0);
    chk("rd_rdata_gated", a_m0_rd, 32'd0);

    // Write from m1.
    m1_req_valid = 1; m1_req_wr = 1; m1_req_addr = 7'h10; m1_req_wdata = 32'h1;
    settle();
    chk("wr_ready", {30'd0, a_m1_ready, a_m0_ready}, 32'd2);
    tick(); m1_req_valid = 0;
    chk("wr_en", {30'd0, a_en, a_wr_en}, 32'd3);
    chk("wr_addr", {25'd0, a_addr}, 32'h10);
    chk("wr_wdata", a_wdata, 32'h1);
    tick();
    chk("wr_en_off", {30'd0, a_en, a_wr_en}, 32'd0);
    tick();
    chk("wr_rv", {30'd0, a_m1_rv, a_m0_rv}, 32'd2);
    chk("wr_rdata", a_m1_rd, 32'd0);
    tick();
    chk("wr_hold_addr", {25'd0, a_addr}, 32'h10);

    // Contention from reset: grants alternate m0, m1, m0, m1 every 4 cycles.
    rst = 1; m1_req_wr = 0;
    tick(); tick();
    rst = 0;
    m0_req_valid = 1; m0_req_addr = 7'h01;
    m1_req_valid = 1; m1_req_addr = 7'h02;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk($sformatf("ct_ready%0d", g), {30'd0, a_m1_ready, a_m0_ready}, (g % 2) ? 32'd2 : 32'd1);
      tick();
      chk($sformatf("ct_addr%0d", g), {25'd0, a_addr}, (g % 2) ? 32'h02 : 32'h01);
      chk($sformatf("ct_noready%0d", g), {30'd0, a_m1_ready, a_m0_ready}, 32'd0);
      tick(); tick();
      chk($sformatf("ct_rv%0d", g), {30'd0, a_m1_rv, a_m0_rv}, (g % 2) ? 32'd2 : 32'd1);
      if (g == 3) begin
        m0_req_valid = 0; m1_req_valid = 0;
      end
      tick();
    end

    // Withdrawal: m1 pulses valid once during m0's WAIT.
    m0_req_valid = 1; m0_req_addr = 7'h05;
    settle();
    chk("wd_ready0", {30'd0, a_m1_ready, a_m0_ready}, 32'd1);
    tick(); m0_req_valid = 0;
    tick(); m1_req_valid = 1; m1_req_addr = 7'h06;
    settle();
    chk("wd_noready", {30'd0, a_m1_ready, a_m0_ready}, 32'd0);
    tick(); m1_req_valid = 0;
    chk("wd_rv", {30'd0, a_m1_rv, a_m0_rv}, 32'd1);
    tick();
    chk("wd_idle", {30'd0, a_busy, a_en}, 32'd0);
    tick();
    chk("wd_idle2", {30'd0, a_busy, a_en}, 32'd0);
    chk("wd_addr", {25'd0, a_addr}, 32'h05);

    // Latency on the LAT=4 instance.
    rst = 1;
    tick(); tick();
    rst = 0; m0_req_valid = 1; m0_req_addr = 7'h33; dmi_rdata = 32'h11111111;
    settle();
    chk("lt_ready", {30'd0, b_m1_ready, b_m0_ready}, 32'd1);
    tick(); m0_req_valid = 0;
    chk("lt_en", {31'd0, b_en}, 32'd1);
    tick(); tick();
    tick(); dmi_rdata = 32'hBAD0BAD0;
    chk("lt_rv3", {30'd0, b_m1_rv, b_m0_rv}, 32'd0);
    tick(); dmi_rdata = 32'hC0FFEE00;
    chk("lt_rv4", {30'd0, b_m1_rv, b_m0_rv}, 32'd0);
    tick(); dmi_rdata = 32'h22222222;
    chk("lt_rv5", {30'd0, b_m1_rv, b_m0_rv}, 32'd1);
    chk("lt_rdata", b_m0_rd, 32'hC0FFEE00);
    tick();
    chk("lt_idle", {31'd0, b_busy}, 32'd0);

    // Reset in WAIT on the LAT=4 instance, with rr left at 1 beforehand.
    m0_req_valid = 1; m0_req_addr = 7'h44;
    settle();
    chk("rw_ready", {30'd0, b_m1_ready, b_m0_ready}, 32'd1);
    tick(); m0_req_valid = 0;
    tick(); rst = 1;
    chk("rw_busy_wait", {31'd0, b_busy}, 32'd1);
    tick();
    rst = 0; m0_req_valid = 1; m1_req_valid = 1; m0_req_addr = 7'h55; dmi_rdata = 32'h5A5A5A5A;
    chk("rw_busy", {31'd0, b_busy}, 32'd0);
    chk("rw_rv", {30'd0, b_m1_rv, b_m0_rv}, 32'd0);
    chk("rw_addr", {25'd0, b_addr}, 32'd0);
    settle();
    chk("rw_rr", {30'd0, b_m1_ready, b_m0_ready}, 32'd1);
    tick(); m0_req_valid = 0; m1_req_valid = 0;
    chk("rw_en", {31'd0, b_en}, 32'd1);
    chk("rw_addr2", {25'd0, b_addr}, 32'h55);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rw_wait%0d", c), {30'd0, b_m1_rv, b_m0_rv}, 32'd0);
    end
    tick();
    chk("rw_resp", {30'd0, b_m1_rv, b_m0_rv}, 32'd1);
    chk("rw_rdata", b_m0_rd, 32'h5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
